if_wb_master: RTL
=================

Name: if_wb_master

Overview:
- Instruction-fetch bus master sitting directly downstream of the PC register.
- Takes the fetch address and chip enable produced each cycle and performs a single Wishbone classic read per instruction.
- Returns the instruction word to the IF/ID stage.
- Raises a stall request while the bus is busy, aborts cleanly on pipeline flush, and substitutes a RISC-V NOP on bus error or timeout.

Parameters:
- TIMEOUT, 255, max cycles waiting for ack/err in BUSY before forced abort (1..255).
- NOP_INST, 32'h00000013, word returned on flush/error/timeout (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- cpu_ce_i  in  1  fetch enable from PC register
- cpu_addr_i  in  32  fetch address (PC)
- stall_i  in  6  pipeline stall vector; bit1 = IF/ID hold
- flush_i  in  1  pipeline flush (exception/redirect)
- cpu_data_o  out  32  fetched instruction to IF/ID
- stallreq_o  out  1  request pipeline stall while fetch outstanding
- fetch_err_o  out  1  one-cycle pulse on bus error or timeout
- wb_adr_o  out  32  Wishbone address
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone ack
- wb_err_i  in  1  Wishbone error
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable, constant 0
- wb_sel_o  out  4  Wishbone byte select

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; wb_cyc/stb/we=0; wb_adr=0; wb_sel=0; rd_buf=0; timer=0; fetch_err_o=0.
- States: IDLE, BUSY, WAIT_STALL. Registered Wishbone outputs; cpu_data_o and stallreq_o combinational.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: next edge drives wb_cyc=wb_stb=1, wb_we=0, wb_sel=4'hF, wb_adr=cpu_addr_i, timer=0 -> BUSY.
  - stallreq_o=1 in that cycle; otherwise stallreq_o=0.
  - cpu_data_o=NOP_INST.
- BUSY, in priority order:
  - flush_i=1: deassert cyc/stb -> IDLE; any same-cycle ack/err is discarded; no err pulse; stallreq_o=0; cpu_data_o=NOP_INST.
  - wb_ack_i=1: deassert cyc/stb; rd_buf<=wb_dat_i; cpu_data_o=wb_dat_i combinationally this cycle; stallreq_o=0. Next state is WAIT_STALL if stall_i[1]=1, else IDLE.
  - wb_err_i=1 (ack=0), or timer==TIMEOUT-1: deassert cyc/stb; rd_buf<=NOP_INST; cpu_data_o=NOP_INST; fetch_err_o=1 next cycle for exactly one cycle; stallreq_o=0. Next state as for ack.
  - Otherwise: timer+=1 (8-bit, saturates, never wraps); stallreq_o=1; cpu_data_o=NOP_INST.
- WAIT_STALL (pipeline frozen after data returned):
  - cpu_data_o=rd_buf; stallreq_o=0; no bus activity.
  - stall_i[1]=0 -> IDLE.
  - flush_i=1 -> IDLE and cpu_data_o=NOP_INST.
- Boundary conditions:
  - ack and err simultaneous: ack wins.
  - cpu_ce_i=0 in BUSY: transaction still completes.
  - cpu_addr_i change mid-BUSY: ignored; wb_adr_o is held until end of cycle.
- Latency: minimum 2 cycles per fetch (issue, ack); at most one outstanding transaction; no back-to-back pipelining.
- Reset mid-transaction: cyc/stb drop at that edge; outstanding ack is ignored.

Test Plan:
- Basic fetch: after reset, ce=1, addr=0x00000000, slave acks 2 cycles after stb with 0x00500093 -> wb_adr_o=0, wb_sel_o=4'hF, stallreq_o=1 for 2 cycles, cpu_data_o=0x00500093 on ack cycle, cyc drops next edge.
- Zero-wait ack: slave acks in first BUSY cycle with 0xDEADBEEF -> stallreq_o high only in IDLE issue cycle; back-to-back fetches of 0x4, 0x8 each take 2 cycles.
- Stall hold: ack with 0x12345678 while stall_i=6'b000011 held 3 cycles -> state WAIT_STALL, cpu_data_o=0x12345678 stable for 3 cycles, no new stb until stall_i[1]=0.
- Flush abort: flush_i=1 in 2nd BUSY cycle with simultaneous ack 0xAAAA5555 -> cyc/stb low next edge, cpu_data_o=0x00000013, fetch_err_o stays 0, next fetch uses new cpu_addr_i.
- Error/timeout: (a) wb_err_i=1 in BUSY -> cpu_data_o=0x00000013, fetch_err_o one-cycle pulse; (b) TIMEOUT=4, no ack -> abort after 4 BUSY cycles, same response.
- Reset mid-operation: rst=0 during BUSY, then ack arrives -> all outputs at reset values, ack ignored, state IDLE.

Source files
------------

// File: rtl/if_wb_master.sv
// rtl/if_wb_master.sv - instruction-fetch Wishbone classic read master
module if_wb_master #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        fetch_err_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  // Last timer value at which a silent slave is given up on.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        wb_stb_q, wb_stb_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [7:0]  timer_q, timer_d;
  logic        fetch_err_q, fetch_err_d;

  logic timed_out;
  assign timed_out = (timer_q == TIMER_LAST);

  // Only the IF/ID hold bit of the stall vector matters to the fetch unit.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    wb_cyc_d    = wb_cyc_q;
    wb_stb_d    = wb_stb_q;
    wb_adr_d    = wb_adr_q;
    wb_sel_d    = wb_sel_q;
    rd_buf_d    = rd_buf_q;
    timer_d     = timer_q;
    fetch_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          state_d  = BUSY;
          wb_cyc_d = 1'b1;
          wb_stb_d = 1'b1;
          wb_sel_d = 4'hF;
          wb_adr_d = cpu_addr_i;
          timer_d  = 8'd0;
        end
      end
      BUSY: begin
        if (flush_i) begin
          // Abort: a same-cycle ack/err belongs to a squashed fetch.
          state_d  = IDLE;
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_sel_d = 4'h0;
        end else if (wb_ack_i) begin
          state_d  = stall_i[1] ? WAIT_STALL : IDLE;
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_sel_d = 4'h0;
          rd_buf_d = wb_dat_i;
        end else if (wb_err_i || timed_out) begin
          state_d     = stall_i[1] ? WAIT_STALL : IDLE;
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          wb_sel_d    = 4'h0;
          rd_buf_d    = NOP_INST;
          fetch_err_d = 1'b1;
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end
      WAIT_STALL: begin
        if (flush_i || !stall_i[1]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered bus outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_adr_q    <= 32'd0;
      wb_sel_q    <= 4'h0;
      rd_buf_q    <= 32'd0;
      timer_q     <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_stb_q    <= wb_stb_d;
      wb_adr_q    <= wb_adr_d;
      wb_sel_q    <= wb_sel_d;
      rd_buf_q    <= rd_buf_d;
      timer_q     <= timer_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Instruction word and stall request seen by the pipeline this cycle.
  always_comb begin
    cpu_data_o = NOP_INST;
    stallreq_o = 1'b0;
    case (state_q)
      IDLE: begin
        stallreq_o = cpu_ce_i && !flush_i;
      end
      BUSY: begin
        if (flush_i) begin
          stallreq_o = 1'b0;
        end else if (wb_ack_i) begin
          cpu_data_o = wb_dat_i;
        end else if (wb_err_i || timed_out) begin
          stallreq_o = 1'b0;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = flush_i ? NOP_INST : rd_buf_q;
      end
      default: begin
        cpu_data_o = NOP_INST;
      end
    endcase
  end

  assign wb_cyc_o    = wb_cyc_q;
  assign wb_stb_o    = wb_stb_q;
  assign wb_adr_o    = wb_adr_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_we_o     = 1'b0;
  assign fetch_err_o = fetch_err_q;

endmodule
